// File: rtl/tt_defs.sv
// Shared definitions for the DL11 console master: register offsets inside
// the DL11 block, default console base address, CSR bit positions and the
// master state encoding.
package tt_defs;

    localparam logic [12:0] TT_CONSOLE_BASE  = 13'o17560;

    localparam logic [12:0] TT_TTI_CSR_OFF   = 13'd0;
    localparam logic [12:0] TT_TTI_DATA_OFF  = 13'd2;
    localparam logic [12:0] TT_TTO_CSR_OFF   = 13'd4;
    localparam logic [12:0] TT_TTO_DATA_OFF  = 13'd6;

    localparam int TT_CSR_READY      = 7;
    localparam int TT_CSR_INT_ENABLE = 6;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RX_CSR   = 3'd1,
        ST_RX_DATA  = 3'd2,
        ST_TX_CSR   = 3'd3,
        ST_TX_DATA  = 3'd4,
        ST_INIT_TTI = 3'd5,
        ST_INIT_TTO = 3'd6
    } tt_state_e;

    typedef enum logic {
        TT_LAST_RX = 1'b0,
        TT_LAST_TX = 1'b1
    } tt_last_e;

endpackage

// File: rtl/tt_hold_reg.sv
// One-entry byte holding register. A byte is captured only while empty and
// released only while full, so load and unload never need arbitration.
module tt_hold_reg (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic       unload,
    output logic       full,
    output logic [7:0] data
);

    logic       full_r;
    logic [7:0] data_r;

    // Capture when empty, drop when consumed; reset discards any held byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full_r <= 1'b0;
            data_r <= 8'h00;
        end else if (full_r) begin
            if (unload) begin
                full_r <= 1'b0;
            end
        end else if (load) begin
            full_r <= 1'b1;
            data_r <= load_data;
        end
    end

    assign full = full_r;
    assign data = data_r;

endmodule

// File: rtl/tt_console_master.sv
// Polling iopage initiator for a DL11 console register block. Moves one tx
// byte from the host into TTO data and one byte from TTI data to the host,
// alternating RX and TX polls so neither direction starves.
// Optional build macro: TT_MASTER_INIT_EN -- when defined, both CSRs are
// written with 0 once after reset (interrupt enables cleared) before polling.
module tt_console_master
    import tt_defs::*;
#(
    parameter logic [12:0] BASE     = TT_CONSOLE_BASE,
    parameter int unsigned POLL_GAP = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic [12:0] iopage_addr,
    output logic [15:0] data_out,
    input  logic [15:0] data_in,
    output logic        iopage_rd,
    output logic        iopage_wr,
    output logic        iopage_byte_op,
    input  logic        tx_valid,
    input  logic [7:0]  tx_data,
    output logic        tx_ready,
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    input  logic        rx_ready,
    output logic        busy
);

    localparam logic [7:0] GAP_RELOAD = 8'(POLL_GAP);

`ifdef TT_MASTER_INIT_EN
    localparam tt_state_e RESET_STATE = ST_INIT_TTI;
`else
    localparam tt_state_e RESET_STATE = ST_IDLE;
`endif

    tt_state_e   state_r;
    logic [7:0]  gap_r;
    tt_last_e    last_r;

    logic        tx_full_s;
    logic [7:0]  tx_byte_s;
    logic        tx_ready_s;
    logic        rx_full_s;
    logic [7:0]  rx_byte_s;

    logic        rd_s;
    logic        wr_s;
    logic [12:0] addr_s;
    logic [15:0] dout_s;

`ifdef TT_MASTER_INIT_EN
    assign tx_ready_s = ~tx_full_s & (state_r != ST_INIT_TTI) & (state_r != ST_INIT_TTO);
`else
    assign tx_ready_s = ~tx_full_s;
`endif

    tt_hold_reg u_tx_hold (
        .clk       (clk),
        .reset     (reset),
        .load      (tx_valid & tx_ready_s),
        .load_data (tx_data),
        .unload    (state_r == ST_TX_DATA),
        .full      (tx_full_s),
        .data      (tx_byte_s)
    );

    tt_hold_reg u_rx_hold (
        .clk       (clk),
        .reset     (reset),
        .load      (state_r == ST_RX_DATA),
        .load_data (data_in[7:0]),
        .unload    (rx_ready),
        .full      (rx_full_s),
        .data      (rx_byte_s)
    );

    // Poll sequencer: gap countdown, round-robin arbitration, CSR ready tests.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= RESET_STATE;
            gap_r   <= GAP_RELOAD;
            last_r  <= TT_LAST_TX;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (gap_r != 8'd0) begin
                        gap_r <= gap_r - 8'd1;
                    end else if (!rx_full_s && ((last_r == TT_LAST_TX) || !tx_full_s)) begin
                        state_r <= ST_RX_CSR;
                        last_r  <= TT_LAST_RX;
                        gap_r   <= GAP_RELOAD;
                    end else if (tx_full_s) begin
                        state_r <= ST_TX_CSR;
                        last_r  <= TT_LAST_TX;
                        gap_r   <= GAP_RELOAD;
                    end
                end
                ST_RX_CSR:  state_r <= data_in[TT_CSR_READY] ? ST_RX_DATA : ST_IDLE;
                ST_RX_DATA: state_r <= ST_IDLE;
                ST_TX_CSR:  state_r <= data_in[TT_CSR_READY] ? ST_TX_DATA : ST_IDLE;
                ST_TX_DATA: state_r <= ST_IDLE;
`ifdef TT_MASTER_INIT_EN
                ST_INIT_TTI: state_r <= ST_INIT_TTO;
                ST_INIT_TTO: state_r <= ST_IDLE;
`endif
                default:    state_r <= ST_IDLE;
            endcase
        end
    end

    // Bus strobes, address and write data decoded from the current state; all quiet in reset.
    always_comb begin
        rd_s   = 1'b0;
        wr_s   = 1'b0;
        addr_s = 13'd0;
        dout_s = 16'h0000;
        if (reset) begin
            case (state_r)
                ST_RX_CSR: begin
                    rd_s   = 1'b1;
                    addr_s = BASE + TT_TTI_CSR_OFF;
                end
                ST_RX_DATA: begin
                    rd_s   = 1'b1;
                    addr_s = BASE + TT_TTI_DATA_OFF;
                end
                ST_TX_CSR: begin
                    rd_s   = 1'b1;
                    addr_s = BASE + TT_TTO_CSR_OFF;
                end
                ST_TX_DATA: begin
                    wr_s   = 1'b1;
                    addr_s = BASE + TT_TTO_DATA_OFF;
                    dout_s = {8'h00, tx_byte_s};
                end
`ifdef TT_MASTER_INIT_EN
                ST_INIT_TTI: begin
                    wr_s   = 1'b1;
                    addr_s = BASE + TT_TTI_CSR_OFF;
                end
                ST_INIT_TTO: begin
                    wr_s   = 1'b1;
                    addr_s = BASE + TT_TTO_CSR_OFF;
                end
`endif
                default: begin
                    rd_s   = 1'b0;
                    wr_s   = 1'b0;
                end
            endcase
        end else begin
            rd_s   = 1'b0;
            wr_s   = 1'b0;
            addr_s = 13'd0;
            dout_s = 16'h0000;
        end
    end

    assign iopage_rd      = rd_s;
    assign iopage_wr      = wr_s;
    assign iopage_addr    = addr_s;
    assign data_out       = dout_s;
    assign iopage_byte_op = 1'b0;
    assign tx_ready       = tx_ready_s;
    assign rx_valid       = rx_full_s;
    assign rx_data        = rx_byte_s;
    assign busy           = (state_r != ST_IDLE) | tx_full_s | rx_full_s;

endmodule

// File: tb/tb_tt_console_master.sv
// Bench for tt_console_master: behavioural DL11 slave, host-side byte
// streams, a bus protocol monitor and an end-to-end byte-order scoreboard.
module tb_tt_console_master;

    localparam int          TB_GAP = 2;
    localparam logic [12:0] BASE   = 13'o17560;
    localparam int          NRAND  = 40;

    logic        clk = 1'b0;
    logic        reset;
    logic [12:0] iopage_addr;
    logic [15:0] iopage_data_out;
    logic [15:0] data_in;
    logic        iopage_rd, iopage_wr, iopage_byte_op;
    logic        tx_valid, tx_ready, rx_valid, rx_ready, busy;
    logic [7:0]  tx_data, rx_data;

    int checks = 0;
    int errors = 0;

    // slave / scoreboard state
    logic       tto_ready;
    logic [7:0] rx_src [0:255];
    int         rx_avail = 0, rx_rd_idx = 0;
    logic [7:0] wr_tx  [0:255];
    int         wr_n = 0;
    logic [7:0] exp_tx [0:255];
    int         exp_n = 0;
    logic [7:0] got_rx [0:255];
    int         got_n = 0;

    // monitor state
    int          cyc = 0, prev_cyc = 0;
    logic        have_prev = 1'b0, prev_ready = 1'b0;
    logic [12:0] prev_addr = 13'd0;
    int          rx_csr_n = 0, tx_csr_n = 0, csr_n = 0;
    int          tx_csr_cyc [0:1023];
    logic [12:0] csr_log    [0:1023];
    logic        is_init_s;

    tt_console_master #(.BASE(BASE), .POLL_GAP(TB_GAP)) dut (
        .clk(clk), .reset(reset), .iopage_addr(iopage_addr), .data_out(iopage_data_out),
        .data_in(data_in), .iopage_rd(iopage_rd), .iopage_wr(iopage_wr),
        .iopage_byte_op(iopage_byte_op), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    assign is_init_s = iopage_wr && (iopage_addr == BASE || iopage_addr == BASE + 13'd4);

    // DL11 slave read data: TTI ready while it holds unread bytes, TTO ready under bench control
    always_comb begin
        data_in = 16'h0000;
        if (iopage_rd) begin
            if (iopage_addr == BASE)
                data_in = (rx_avail > rx_rd_idx) ? 16'o000300 : 16'o000100;
            else if (iopage_addr == BASE + 13'd2)
                data_in = {8'hA5, rx_src[rx_rd_idx]};
            else if (iopage_addr == BASE + 13'd4)
                data_in = tto_ready ? 16'o000200 : 16'o000000;
        end
    end

    // Slave captures and host handshakes, taken at the clock edge like real endpoints
    always @(posedge clk) begin
        if (reset) begin
            if (iopage_wr && iopage_addr == BASE + 13'd6) begin
                wr_tx[wr_n] <= iopage_data_out[7:0];
                wr_n        <= wr_n + 1;
            end
            if (iopage_rd && iopage_addr == BASE + 13'd2) rx_rd_idx <= rx_rd_idx + 1;
            if (tx_valid && tx_ready) begin
                exp_tx[exp_n] <= tx_data;
                exp_n         <= exp_n + 1;
            end
            if (rx_valid && rx_ready) begin
                got_rx[got_n] <= rx_data;
                got_n         <= got_n + 1;
            end
        end
    end

    // Bus protocol monitor, sampled mid-cycle
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!reset) begin
            have_prev <= 1'b0;
        end else begin
            check("byte_op_zero", iopage_byte_op, 0);
            if (iopage_rd || iopage_wr) begin
                check("rd_wr_exclusive", iopage_rd & iopage_wr, 0);
                if (have_prev && !is_init_s) begin
                    if (prev_ready) begin
                        check("follow_gap", cyc - prev_cyc, 1);
                        check("follow_addr", iopage_addr, prev_addr + 13'd2);
                        check("follow_kind_wr", iopage_wr, prev_addr == BASE + 13'd4);
                    end else begin
                        check("poll_gap_min", (cyc - prev_cyc) >= TB_GAP + 2, 1);
                        check("poll_is_csr_read",
                              iopage_rd && (iopage_addr == BASE || iopage_addr == BASE + 13'd4), 1);
                    end
                end
                if (iopage_wr && iopage_addr == BASE + 13'd6)
                    check("tx_write_hi_zero", iopage_data_out[15:8], 0);
                if (iopage_rd && iopage_addr == BASE) begin
                    check("no_rx_poll_while_full", rx_valid, 0);
                    rx_csr_n <= rx_csr_n + 1;
                    csr_log[csr_n % 1024] <= iopage_addr;
                    csr_n <= csr_n + 1;
                end
                if (iopage_rd && iopage_addr == BASE + 13'd4) begin
                    tx_csr_cyc[tx_csr_n % 1024] <= cyc;
                    tx_csr_n <= tx_csr_n + 1;
                    csr_log[csr_n % 1024] <= iopage_addr;
                    csr_n <= csr_n + 1;
                end
                if (is_init_s) begin
                    have_prev <= 1'b0;
                end else begin
                    have_prev  <= 1'b1;
                    prev_cyc   <= cyc;
                    prev_addr  <= iopage_addr;
                    prev_ready <= iopage_rd && (iopage_addr == BASE || iopage_addr == BASE + 13'd4)
                                  && data_in[7];
                end
            end else begin
                check("idle_bus_zero", {iopage_addr, iopage_data_out}, 0);
            end
        end
    end

    // Offer one byte from the host; returns at the negedge after the accepting edge
    task automatic send_tx(input logic [7:0] b);
        int g;
        tx_valid = 1'b1;
        tx_data  = b;
        g = 0;
        while (!tx_ready && g < 2000) begin
            @(negedge clk);
            g++;
        end
        check("tx_accept_in_time", g < 2000, 1);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic push_rx(input logic [7:0] b);
        rx_src[rx_avail] = b;
        rx_avail++;
    endtask

    initial begin
        int g, k, s, s2, w0, r0, t0, d_cyc, v_cyc, rx_base, w_base;
        reset = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0; tto_ready = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_strobes", {iopage_rd, iopage_wr}, 0);
        check("rst_addr_data", {iopage_addr, iopage_data_out}, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 8'h00);
`ifdef TT_MASTER_INIT_EN
        check("rst_tx_ready", tx_ready, 0);
        reset = 1'b1;
        #1;
        check("init_tti_wr", {iopage_rd, iopage_wr, iopage_addr, iopage_data_out}, {2'b01, BASE, 16'h0000});
        check("init_tx_ready0", tx_ready, 0);
        @(negedge clk);
        check("init_tto_wr", {iopage_rd, iopage_wr, iopage_addr, iopage_data_out},
              {2'b01, BASE + 13'd4, 16'h0000});
        check("init_tx_ready1", tx_ready, 0);
        @(negedge clk);
        check("init_done_tx_ready", tx_ready, 1);
`else
        check("rst_tx_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        reset = 1'b1;
        @(negedge clk);
`endif
        repeat (10) @(negedge clk);

        // single tx byte, TTO ready
        tto_ready = 1'b1;
        send_tx(8'h41);
        g = 0;
        while (!iopage_wr && g < 200) begin @(negedge clk); g++; end
        check("t2_write_seen", g < 200, 1);
        check("t2_write_addr", iopage_addr, 13'o17566);
        check("t2_write_data", iopage_data_out, 16'h0041);
        check("t2_tx_ready_during", tx_ready, 0);
        @(negedge clk);
        check("t2_tx_ready_after", tx_ready, 1);
        repeat (10) @(negedge clk);

        // TTO busy for three polls, then ready
        tto_ready = 1'b0;
        w0 = wr_n;
        t0 = tx_csr_n;
        send_tx(8'h33);
        g = 0;
        while (tx_csr_n < t0 + 3 && g < 500) begin @(negedge clk); g++; end
        check("t3_three_polls", g < 500, 1);
        check("t3_no_early_write", wr_n - w0, 0);
        check("t3_poll_spacing1", tx_csr_cyc[(t0 + 1) % 1024] - tx_csr_cyc[t0 % 1024], 2 * (TB_GAP + 2));
        check("t3_poll_spacing2", tx_csr_cyc[(t0 + 2) % 1024] - tx_csr_cyc[(t0 + 1) % 1024], 2 * (TB_GAP + 2));
        tto_ready = 1'b1;
        g = 0;
        while (wr_n == w0 && g < 500) begin @(negedge clk); g++; end
        repeat (20) @(negedge clk);
        check("t3_one_write", wr_n - w0, 1);
        check("t3_tx_polls_total", tx_csr_n - t0, 4);
        check("t3_write_data", wr_tx[w0], 8'h33);

        // rx byte held while the host is not ready
        push_rx(8'h5A);
        push_rx(8'h6B);
        g = 0; k = 0; d_cyc = -100; v_cyc = -1;
        while (!rx_valid && g < 500) begin
            if (iopage_rd && iopage_addr == BASE + 13'd2) d_cyc = k;
            @(negedge clk); g++; k++;
        end
        v_cyc = k;
        check("t4_rx_valid_seen", g < 500, 1);
        check("t4_rx_latency", v_cyc - d_cyc, 1);
        check("t4_rx_data", rx_data, 8'h5A);
        @(negedge clk);
        r0 = rx_csr_n;
        repeat (40) @(negedge clk);
        check("t4_no_poll_while_full", rx_csr_n - r0, 0);
        check("t4_still_held", {rx_valid, rx_data}, {1'b1, 8'h5A});
        rx_ready = 1'b1; @(negedge clk); rx_ready = 1'b0;
        g = 0;
        while (!rx_valid && g < 500) begin @(negedge clk); g++; end
        check("t4_second_byte", {rx_valid, rx_data}, {1'b1, 8'h6B});
        rx_ready = 1'b1; @(negedge clk); rx_ready = 1'b0;
        repeat (5) @(negedge clk);

        // tx stalled with rx pending: polls alternate, rx gets through
        tto_ready = 1'b0;
        rx_ready  = 1'b1;
        send_tx(8'h55);
        s = csr_n;
        g = 0;
        while (csr_n < s + 6 && g < 500) begin @(negedge clk); g++; end
        for (int i = s + 1; i < s + 6; i++)
            check("t5_alternate", csr_log[i % 1024] != csr_log[(i - 1) % 1024], 1);
        r0 = rx_rd_idx;
        push_rx(8'h77);
        s2 = csr_n;
        g = 0;
        while (rx_rd_idx == r0 && g < 500) begin @(negedge clk); g++; end
        check("t5_rx_within_2_slots", (g < 500) && (csr_n - s2 <= 2), 1);
        w0 = wr_n;
        tto_ready = 1'b1;
        g = 0;
        while (wr_n == w0 && g < 500) begin @(negedge clk); g++; end
        check("t5_tx_drained", g < 500, 1);
        repeat (5) @(negedge clk);
        rx_ready = 1'b0;

        // randomized traffic in both directions
        rx_base = rx_avail;
        w_base  = wr_n;
        fork
            begin
                for (int i = 0; i < NRAND; i++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    send_tx(8'($urandom));
                end
            end
            begin : rx_host
                int gb;
                gb = 0;
                while (got_n < rx_base + NRAND && gb < 20000) begin
                    @(negedge clk);
                    rx_ready = ($urandom_range(0, 2) != 0);
                    gb++;
                end
                rx_ready = 1'b0;
            end
            begin : slave_side
                int gc;
                gc = 0;
                while ((got_n < rx_base + NRAND || wr_n < w_base + NRAND) && gc < 20000) begin
                    @(negedge clk);
                    if (rx_avail < rx_base + NRAND && $urandom_range(0, 3) == 0)
                        push_rx(8'($urandom));
                    tto_ready = $urandom_range(0, 1);
                    gc++;
                end
                tto_ready = 1'b1;
            end
        join
        repeat (30) @(negedge clk);

        // end-to-end byte streams against the scoreboard
        check("sb_tx_count", wr_n, exp_n);
        for (int i = 0; i < exp_n; i++) check("sb_tx_byte", wr_tx[i], exp_tx[i]);
        check("sb_rx_count", got_n, rx_avail);
        for (int i = 0; i < got_n; i++) check("sb_rx_byte", got_rx[i], rx_src[i]);
        check("sb_idle_busy", busy, 0);

        // reset during a TTO data write aborts it and drops the byte
        tto_ready = 1'b1;
        send_tx(8'h99);
        g = 0;
        while (!iopage_wr && g < 200) begin @(negedge clk); g++; end
        check("rst_mid_write_reached", g < 200, 1);
        w0 = wr_n;
        reset = 1'b0;
        #1;
        check("rst_mid_strobes", {iopage_rd, iopage_wr}, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mid_tx_ready", tx_ready, 1);
        check("rst_mid_rx_valid", rx_valid, 0);
        repeat (20) @(negedge clk);
        check("rst_mid_no_write", wr_n - w0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
